// File: rtl/ycbcr2rgb_csc.sv
// YCbCr to RGB colour-space converter: BT.601/BT.709 limited and BT.601 full range,
// three register stages (products, rounded sums, shift+saturate) with valid/ready flow control.
module ycbcr2rgb_csc #(
    parameter int DSIZE = 8,
    parameter int MSIZE = 12
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [1:0]         mode,
    input  logic               in_vld,
    output logic               in_rdy,
    input  logic               in_sof,
    input  logic               in_eol,
    input  logic [3*DSIZE-1:0] y_cb_cr,
    output logic               rgb_vld,
    input  logic               rgb_rdy,
    output logic               rgb_sof,
    output logic               rgb_eol,
    output logic [3*DSIZE-1:0] rgb
);

    localparam int CW = MSIZE + 3;
    localparam int AW = DSIZE + MSIZE + 4;
    localparam int VW = DSIZE + 1;

    typedef logic signed [CW-1:0] coef_t;
    typedef logic signed [AW-1:0] acc_t;
    typedef logic signed [VW-1:0] val_t;

    // Coefficients are given in thousandths; this is round-half-up of c * 2^MSIZE.
    function automatic coef_t to_coef(input int milli);
        int v;
        v = (milli * (1 << MSIZE) + 500) / 1000;
        return coef_t'(v);
    endfunction

    localparam coef_t KY_L  = to_coef(1164);
    localparam coef_t RCR_0 = to_coef(1596);
    localparam coef_t GCB_0 = to_coef(392);
    localparam coef_t GCR_0 = to_coef(813);
    localparam coef_t BCB_0 = to_coef(2017);
    localparam coef_t RCR_1 = to_coef(1793);
    localparam coef_t GCB_1 = to_coef(213);
    localparam coef_t GCR_1 = to_coef(533);
    localparam coef_t BCB_1 = to_coef(2112);
    localparam coef_t KY_F  = to_coef(1000);
    localparam coef_t RCR_2 = to_coef(1402);
    localparam coef_t GCB_2 = to_coef(344);
    localparam coef_t GCR_2 = to_coef(714);
    localparam coef_t BCB_2 = to_coef(1772);

    localparam logic [DSIZE-1:0] Y_OFF = DSIZE'(16 << (DSIZE - 8));
    localparam logic [DSIZE-1:0] C_OFF = DSIZE'(128 << (DSIZE - 8));
    localparam acc_t RND   = acc_t'(1 << (MSIZE - 1));
    localparam acc_t MAX_V = acc_t'((1 << DSIZE) - 1);

    function automatic logic [DSIZE-1:0] sat(input acc_t s);
        acc_t t;
        t = s >>> MSIZE;
        if (t[AW-1])
            return '0;
        else if (t > MAX_V)
            return '1;
        else
            return t[DSIZE-1:0];
    endfunction

    // Handshake: a pixel transfers on in_vld && in_rdy and leaves on rgb_vld && rgb_rdy;
    // the whole pipe freezes only while an output pixel is held back, so in_rdy = !stall.
    logic stall;
    logic take;
    assign stall  = rgb_vld && !rgb_rdy;
    assign in_rdy = !stall;
    assign take   = in_vld && in_rdy;

    logic [1:0] mode_q;
    logic [1:0] mode_in;
    logic [1:0] mode_eff;
    assign mode_in  = (mode == 2'd3) ? 2'd0 : mode;
    assign mode_eff = (take && in_sof) ? mode_in : mode_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            mode_q <= 2'd0;
        else if (take && in_sof)
            mode_q <= mode_in;
    end

    coef_t ky, rcr, gcb, gcr, bcb;
    always_comb begin
        ky  = KY_L;
        rcr = RCR_0;
        gcb = GCB_0;
        gcr = GCR_0;
        bcb = BCB_0;
        case (mode_eff)
            2'd1: begin
                rcr = RCR_1;
                gcb = GCB_1;
                gcr = GCR_1;
                bcb = BCB_1;
            end
            2'd2: begin
                ky  = KY_F;
                rcr = RCR_2;
                gcb = GCB_2;
                gcr = GCR_2;
                bcb = BCB_2;
            end
            default: ;
        endcase
    end

    logic [DSIZE-1:0] y_off;
    val_t y_v, cb_v, cr_v;
    assign y_off = (mode_eff == 2'd2) ? '0 : Y_OFF;
    assign y_v   = $signed({1'b0, y_cb_cr[3*DSIZE-1 -: DSIZE]}) - $signed({1'b0, y_off});
    assign cb_v  = $signed({1'b0, y_cb_cr[2*DSIZE-1 -: DSIZE]}) - $signed({1'b0, C_OFF});
    assign cr_v  = $signed({1'b0, y_cb_cr[DSIZE-1:0]}) - $signed({1'b0, C_OFF});

    logic s1_vld, s1_sof, s1_eol;
    logic s2_vld, s2_sof, s2_eol;
    acc_t p_ky, p_rcr, p_gcb, p_gcr, p_bcb;
    acc_t r_sum, g_sum, b_sum;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_vld  <= 1'b0;
            s1_sof  <= 1'b0;
            s1_eol  <= 1'b0;
            p_ky    <= '0;
            p_rcr   <= '0;
            p_gcb   <= '0;
            p_gcr   <= '0;
            p_bcb   <= '0;
            s2_vld  <= 1'b0;
            s2_sof  <= 1'b0;
            s2_eol  <= 1'b0;
            r_sum   <= '0;
            g_sum   <= '0;
            b_sum   <= '0;
            rgb_vld <= 1'b0;
            rgb_sof <= 1'b0;
            rgb_eol <= 1'b0;
            rgb     <= '0;
        end else if (!stall) begin
            s1_vld  <= in_vld;
            s1_sof  <= in_vld && in_sof;
            s1_eol  <= in_vld && in_eol;
            p_ky    <= acc_t'(ky) * acc_t'(y_v);
            p_rcr   <= acc_t'(rcr) * acc_t'(cr_v);
            p_gcb   <= acc_t'(gcb) * acc_t'(cb_v);
            p_gcr   <= acc_t'(gcr) * acc_t'(cr_v);
            p_bcb   <= acc_t'(bcb) * acc_t'(cb_v);
            s2_vld  <= s1_vld;
            s2_sof  <= s1_sof;
            s2_eol  <= s1_eol;
            r_sum   <= p_ky + p_rcr + RND;
            g_sum   <= p_ky - p_gcb - p_gcr + RND;
            b_sum   <= p_ky + p_bcb + RND;
            rgb_vld <= s2_vld;
            rgb_sof <= s2_sof;
            rgb_eol <= s2_eol;
            rgb     <= {sat(r_sum), sat(g_sum), sat(b_sum)};
        end
    end

endmodule

// File: tb/tb_ycbcr2rgb_csc.sv
// Bench for ycbcr2rgb_csc: directed latency/mode/backpressure/reset steps on an 8/12 instance
// and a random stream on a 10/14 instance, both scored against an integer colour model.
module tb_ycbcr2rgb_csc;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;

    // ---------------- 8-bit instance ----------------
    logic [1:0]  a_mode;
    logic        a_in_vld, a_in_rdy, a_sof, a_eol;
    logic [23:0] a_pix;
    logic        a_vld, a_rdy, a_osof, a_oeol;
    logic [23:0] a_rgb;

    ycbcr2rgb_csc #(.DSIZE(8), .MSIZE(12)) dut8 (
        .clock(clock), .reset_n(reset_n), .mode(a_mode),
        .in_vld(a_in_vld), .in_rdy(a_in_rdy), .in_sof(a_sof), .in_eol(a_eol),
        .y_cb_cr(a_pix), .rgb_vld(a_vld), .rgb_rdy(a_rdy),
        .rgb_sof(a_osof), .rgb_eol(a_oeol), .rgb(a_rgb)
    );

    // ---------------- 10-bit instance ----------------
    logic [1:0]  b_mode;
    logic        b_in_vld, b_in_rdy, b_sof, b_eol;
    logic [29:0] b_pix;
    logic        b_vld, b_rdy, b_osof, b_oeol;
    logic [29:0] b_rgb;

    ycbcr2rgb_csc #(.DSIZE(10), .MSIZE(14)) dut10 (
        .clock(clock), .reset_n(reset_n), .mode(b_mode),
        .in_vld(b_in_vld), .in_rdy(b_in_rdy), .in_sof(b_sof), .in_eol(b_eol),
        .y_cb_cr(b_pix), .rgb_vld(b_vld), .rgb_rdy(b_rdy),
        .rgb_sof(b_osof), .rgb_eol(b_oeol), .rgb(b_rgb)
    );

    // ---------------- reference model ----------------
    localparam int KT [3][5] = '{
        '{1164, 1596, 392, 813, 2017},
        '{1164, 1793, 213, 533, 2112},
        '{1000, 1402, 344, 714, 1772}
    };

    function automatic longint model(input int d, input int m, input int md,
                                     input int yy, input int cb, input int cr);
        longint c[5];
        longint yv, cbv, crv;
        longint s[3];
        longint res;
        for (int i = 0; i < 5; i++)
            c[i] = (longint'(KT[md][i]) * (longint'(1) << m) + 500) / 1000;
        yv  = yy - ((md == 2) ? 0 : (16 << (d - 8)));
        cbv = cb - (128 << (d - 8));
        crv = cr - (128 << (d - 8));
        s[0] = c[0] * yv + c[1] * crv;
        s[1] = c[0] * yv - c[2] * cbv - c[3] * crv;
        s[2] = c[0] * yv + c[4] * cbv;
        res = 0;
        for (int i = 0; i < 3; i++) begin
            s[i] = (s[i] + (longint'(1) << (m - 1))) >>> m;
            if (s[i] < 0) s[i] = 0;
            if (s[i] > (longint'(1) << d) - 1) s[i] = (longint'(1) << d) - 1;
            res = (res << d) | s[i];
        end
        return res;
    endfunction

    // ---------------- check helper ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // ---------------- scoreboards ----------------
    logic [25:0] a_q[$];
    logic [31:0] b_q[$];
    logic [1:0]  a_model_mode = 2'd0;
    logic [1:0]  b_model_mode = 2'd0;
    logic        a_prev_stall = 1'b0;
    logic        b_prev_stall = 1'b0;
    logic [25:0] a_prev;
    logic [31:0] b_prev;

    always @(negedge clock) begin
        longint px;
        logic [25:0] e;
        if (!reset_n) begin
            a_q.delete();
            a_model_mode = 2'd0;
            a_prev_stall = 1'b0;
        end else begin
            check("a_in_rdy", a_in_rdy, !(a_vld && !a_rdy));
            if (a_prev_stall)
                check("a_hold", {a_vld, a_rgb, a_osof, a_oeol}, {1'b1, a_prev});
            if (a_vld && a_rdy) begin
                check("a_out_expected", a_q.size() > 0, 1'b1);
                if (a_q.size() > 0) begin
                    e = a_q.pop_front();
                    check("a_out", {a_rgb, a_osof, a_oeol}, e);
                end
            end
            if (a_in_vld && a_in_rdy) begin
                if (a_sof) a_model_mode = (a_mode == 2'd3) ? 2'd0 : a_mode;
                px = model(8, 12, int'(a_model_mode), int'(a_pix[23:16]), int'(a_pix[15:8]), int'(a_pix[7:0]));
                a_q.push_back({px[23:0], a_sof, a_eol});
            end
            a_prev_stall = a_vld && !a_rdy;
            a_prev = {a_rgb, a_osof, a_oeol};
        end
    end

    always @(negedge clock) begin
        longint px;
        logic [31:0] e;
        if (!reset_n) begin
            b_q.delete();
            b_model_mode = 2'd0;
            b_prev_stall = 1'b0;
        end else begin
            check("b_in_rdy", b_in_rdy, !(b_vld && !b_rdy));
            if (b_prev_stall)
                check("b_hold", {b_vld, b_rgb, b_osof, b_oeol}, {1'b1, b_prev});
            if (b_vld && b_rdy) begin
                check("b_out_expected", b_q.size() > 0, 1'b1);
                if (b_q.size() > 0) begin
                    e = b_q.pop_front();
                    check("b_out", {b_rgb, b_osof, b_oeol}, e);
                end
            end
            if (b_in_vld && b_in_rdy) begin
                if (b_sof) b_model_mode = (b_mode == 2'd3) ? 2'd0 : b_mode;
                px = model(10, 14, int'(b_model_mode), int'(b_pix[29:20]), int'(b_pix[19:10]), int'(b_pix[9:0]));
                b_q.push_back({px[29:0], b_sof, b_eol});
            end
            b_prev_stall = b_vld && !b_rdy;
            b_prev = {b_rgb, b_osof, b_oeol};
        end
    end

    // ---------------- driver tasks ----------------
    // Sends one pixel into an empty 8-bit pipe and measures edges until it appears.
    task automatic lat_check(input string tag, input logic [23:0] pix, input logic sof,
                             input logic [23:0] exp);
        int n;
        a_pix = pix;
        a_sof = sof;
        a_eol = 1'b0;
        a_in_vld = 1'b1;
        step();
        a_in_vld = 1'b0;
        a_sof = 1'b0;
        n = 1;
        while (!a_vld && n < 10) begin
            step();
            n++;
        end
        check({tag, "_latency"}, n, 3);
        check({tag, "_rgb"}, a_rgb, exp);
        step();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int idx, c, low, acc_n, cyc;
        bit acc, pend;

        a_mode = 2'd0; a_in_vld = 1'b0; a_sof = 1'b0; a_eol = 1'b0; a_pix = '0; a_rdy = 1'b1;
        b_mode = 2'd0; b_in_vld = 1'b0; b_sof = 1'b0; b_eol = 1'b0; b_pix = '0; b_rdy = 1'b1;

        #2;
        check("rst_vld", a_vld, 1'b0);
        check("rst_rgb", a_rgb, 24'h0);
        check("rst_in_rdy", a_in_rdy, 1'b1);
        check("rst_vld10", b_vld, 1'b0);
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;
        step();

        // mode 0 black / white / clamped
        lat_check("m0_black", {8'd16, 8'd128, 8'd128}, 1'b1, 24'h000000);
        lat_check("m0_white", {8'd235, 8'd128, 8'd128}, 1'b0, 24'hffffff);
        lat_check("m0_low", {8'd16, 8'd16, 8'd16}, 1'b0, {8'd0, 8'd135, 8'd0});

        // mode switch only on sof
        a_mode = 2'd2;
        lat_check("m2_grey", {8'd100, 8'd128, 8'd128}, 1'b1, {8'd100, 8'd100, 8'd100});
        a_mode = 2'd0;
        lat_check("m2_kept", {8'd100, 8'd128, 8'd128}, 1'b0, {8'd100, 8'd100, 8'd100});
        lat_check("m0_next", {8'd100, 8'd128, 8'd128}, 1'b1, {8'd98, 8'd98, 8'd98});
        a_mode = 2'd3;
        lat_check("m3_as_m0", {8'd235, 8'd128, 8'd128}, 1'b1, 24'hffffff);
        a_mode = 2'd0;

        // rgb_rdy low with an empty pipe has no effect on in_rdy
        a_rdy = 1'b0;
        #1 check("idle_rdy", a_in_rdy, 1'b1);
        a_rdy = 1'b1;
        step();

        // backpressure: 20 pixels, rgb_rdy low for 5 cycles mid-stream
        a_mode = 2'd1;
        idx = 0; c = 0; low = 0;
        while (idx < 20 && c < 100) begin
            a_rdy = !(c >= 8 && c < 13);
            a_in_vld = 1'b1;
            a_pix = {8'(20 + idx * 10), 8'(60 + idx * 7), 8'(200 - idx * 6)};
            a_sof = (idx == 0);
            a_eol = (idx == 9 || idx == 19);
            @(negedge clock);
            acc = a_in_rdy;
            if (!a_in_rdy) low++;
            @(posedge clock);
            #1;
            if (acc) idx++;
            c++;
        end
        a_in_vld = 1'b0; a_sof = 1'b0; a_eol = 1'b0; a_rdy = 1'b1;
        check("bp_sent", idx, 20);
        check("bp_in_rdy_low", low, 5);
        repeat (6) step();
        check("bp_drained", a_q.size(), 0);

        // reset with three pixels in flight, in mode 2
        a_mode = 2'd2;
        for (int i = 0; i < 3; i++) begin
            a_in_vld = 1'b1;
            a_pix = {8'(50 + i * 40), 8'd90, 8'd170};
            a_sof = (i == 0);
            step();
        end
        a_in_vld = 1'b0; a_sof = 1'b0;
        check("rst_inflight", a_vld, 1'b1);
        #1 reset_n = 1'b0;
        #1;
        check("rst_async_vld", a_vld, 1'b0);
        check("rst_async_rgb", a_rgb, 24'h0);
        check("rst_async_sof", a_osof, 1'b0);
        check("rst_async_in_rdy", a_in_rdy, 1'b1);
        @(posedge clock);
        #1 check("rst_held_vld", a_vld, 1'b0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        @(posedge clock);
        #1;
        // active mode must be back to 0; the mode input is ignored without sof
        lat_check("rst_first", {8'd100, 8'd128, 8'd128}, 1'b0, {8'd98, 8'd98, 8'd98});
        repeat (4) step();
        check("rst_no_old", a_q.size(), 0);
        a_mode = 2'd0;

        // 10-bit random stream, mode 1 latched on sof, random mode noise otherwise
        acc_n = 0; cyc = 0; pend = 1'b0;
        while (acc_n < 10000 && cyc < 40000) begin
            b_rdy = ($urandom_range(0, 3) != 0);
            if (!pend) begin
                b_in_vld = ($urandom_range(0, 4) != 0);
                b_sof = (acc_n == 0) || ($urandom_range(0, 299) == 0);
                b_eol = ($urandom_range(0, 63) == 0);
                b_pix = {10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
                         10'($urandom_range(0, 1023))};
                b_mode = b_sof ? 2'd1 : 2'($urandom_range(0, 3));
            end
            @(negedge clock);
            acc = b_in_vld && b_in_rdy;
            pend = b_in_vld && !b_in_rdy;
            @(posedge clock);
            #1;
            if (acc) acc_n++;
            cyc++;
        end
        b_in_vld = 1'b0; b_sof = 1'b0; b_eol = 1'b0; b_rdy = 1'b1;
        repeat (8) step();
        check("rnd_count", acc_n, 10000);
        check("rnd_drained", b_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
